// File: rtl/segs_bcd_feeder.sv
// Sequential 20-bit binary to six-digit BCD converter (double-dabble, one bit per clock)
// that feeds the seven-segment scan controller with packed digits and leading-zero blanking.
module segs_bcd_feeder #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Load,
  input  logic [19:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic        Overflow,
  output logic [23:0] Data,
  output logic [5:0]  DisplayEnables,
  output logic [1:0]  state_dbg
);

  // Handshake: Load is taken on a rising edge only while Busy=0 (IDLE); Busy rises after
  // that edge and falls together with the one-cycle Done pulse. Load at any other time is dropped.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [19:0] shift_q;
  logic [23:0] acc_q;
  logic [23:0] acc_adj;
  logic [4:0]  cnt_q;
  logic        ovf_pend;
  logic [5:0]  en_blank;
  logic        seen_nz;

  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Load) state_next = CONV;
      CONV:    if (cnt_q == 5'd1) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble in parallel, no carry between nibbles.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 6; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // A digit is shown when it or any more significant digit is nonzero; ones digit always shown.
  always_comb begin
    en_blank = 6'b000000;
    seen_nz  = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      seen_nz     = seen_nz | (acc_q[4*i +: 4] != 4'd0);
      en_blank[i] = seen_nz;
    end
    en_blank[0] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      shift_q        <= 20'd0;
      acc_q          <= 24'd0;
      cnt_q          <= 5'd0;
      ovf_pend       <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Overflow       <= 1'b0;
      Data           <= 24'h000000;
      DisplayEnables <= 6'b000001;
    end else begin
      state <= state_next;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (Load) begin
            shift_q  <= Value;
            acc_q    <= 24'd0;
            cnt_q    <= 5'd20;
            ovf_pend <= (Value > 20'd999999);
            Busy     <= 1'b1;
          end
        end
        CONV: begin
          acc_q   <= {acc_adj[22:0], shift_q[19]};
          shift_q <= {shift_q[18:0], 1'b0};
          cnt_q   <= cnt_q - 5'd1;
        end
        FINISH: begin
          Busy <= 1'b0;
          Done <= 1'b1;
          if (ovf_pend) begin
            Data           <= 24'h999999;
            DisplayEnables <= 6'b111111;
            Overflow       <= 1'b1;
          end else begin
            Data           <= acc_q;
            DisplayEnables <= BLANK_LEADING ? en_blank : 6'b111111;
            Overflow       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_segs_bcd_feeder.sv
// Self-checking bench for segs_bcd_feeder: one blanking and one non-blanking instance share
// inputs; results are checked against a decimal-arithmetic reference model.
module tb_segs_bcd_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] value = 20'd0;

  logic        busy, done, ovf;
  logic [23:0] data;
  logic [5:0]  en;
  logic [1:0]  sd0;
  logic        busy1, done1, ovf1;
  logic [23:0] data1;
  logic [5:0]  en1;
  logic [1:0]  sd1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [30:0] exp_q[$];
  logic [30:0] exp1_q[$];

  segs_bcd_feeder #(.BLANK_LEADING(1'b1)) u_blank (
    .Clock(clk), .Reset_n(rst_n), .Load(load), .Value(value),
    .Busy(busy), .Done(done), .Overflow(ovf), .Data(data),
    .DisplayEnables(en), .state_dbg(sd0)
  );

  segs_bcd_feeder #(.BLANK_LEADING(1'b0)) u_full (
    .Clock(clk), .Reset_n(rst_n), .Load(load), .Value(value),
    .Busy(busy1), .Done(done1), .Overflow(ovf1), .Data(data1),
    .DisplayEnables(en1), .state_dbg(sd1)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: decimal digits by division, result packed as {ovf, en, data}.
  function automatic logic [30:0] ref_model(input int unsigned v, input bit blank);
    logic [23:0] d;
    logic [5:0]  e;
    int unsigned rem;
    int          top;
    if (v > 999999) return {1'b1, 6'b111111, 24'h999999};
    d   = 24'd0;
    rem = v;
    top = 0;
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = 4'(rem % 10);
      if (rem % 10 != 0) top = i;
      rem = rem / 10;
    end
    for (int i = 0; i < 6; i++) e[i] = blank ? (i <= top) : 1'b1;
    return {1'b0, e, d};
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_load(input logic [19:0] v);
    value = v;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (done !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if ({busy, done, ovf, en, data} !== {1'b0, 1'b0, 1'b0, 6'b000001, 24'h0}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b done=%b ovf=%b en=%b data=%h, want 0 0 0 000001 000000",
               busy, done, ovf, en, data);
    end
    n_checks++;
    if ({busy1, done1, ovf1, en1, data1} !== {1'b0, 1'b0, 1'b0, 6'b000001, 24'h0}) begin
      n_fail++;
      $display("FAIL reset_values_full: got en=%b data=%h, want 000001 000000", en1, data1);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_zero();
    int lat;
    start_load(20'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_busy_after_accept: got %b want 1", busy);
    end
    wait_done(lat);
    n_checks++;
    if (lat != 21) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d want 21", lat);
    end
    n_checks++;
    if ({ovf, en, data} !== ref_model(0, 1'b1)) begin
      n_fail++;
      $display("FAIL zero_result: got %h want %h", {ovf, en, data}, ref_model(0, 1'b1));
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy_at_done: got %b want 0", busy);
    end
    tick(1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_sequence();
    int lat;
    int cycles;
    int hold_bad;
    int busy_bad;
    start_load(20'd123456);
    wait_done(lat);
    n_checks++;
    if ({ovf, en, data} !== {1'b0, 6'b111111, 24'h123456}) begin
      n_fail++;
      $display("FAIL seq_123456: got %h want %h", {ovf, en, data}, {1'b0, 6'b111111, 24'h123456});
    end
    start_load(20'd1007);
    cycles = 0;
    hold_bad = 0;
    busy_bad = 0;
    do begin
      tick(1);
      cycles++;
      if (done !== 1'b1 && data !== 24'h123456) hold_bad++;
      if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
    end while (done !== 1'b1 && cycles < 40);
    n_checks++;
    if (hold_bad != 0 || busy_bad != 0) begin
      n_fail++;
      $display("FAIL seq_hold: data changed in %0d cycles, busy low in %0d cycles, want 0 and 0",
               hold_bad, busy_bad);
    end
    n_checks++;
    if (cycles != 21) begin
      n_fail++;
      $display("FAIL seq_latency: got %0d want 21", cycles);
    end
    n_checks++;
    if ({ovf, en, data} !== {1'b0, 6'b001111, 24'h001007}) begin
      n_fail++;
      $display("FAIL seq_1007: got %h want %h", {ovf, en, data}, {1'b0, 6'b001111, 24'h001007});
    end
  endtask

  task automatic test_boundary();
    int unsigned vals[5] = '{999999, 1000000, 5, 1048575, 100000};
    int lat;
    foreach (vals[k]) begin
      start_load(20'(vals[k]));
      wait_done(lat);
      n_checks++;
      if (lat != 21 || {ovf, en, data} !== ref_model(vals[k], 1'b1)) begin
        n_fail++;
        $display("FAIL boundary_%0d: got lat=%0d res=%h want lat=21 res=%h",
                 vals[k], lat, {ovf, en, data}, ref_model(vals[k], 1'b1));
      end
    end
  endtask

  task automatic test_ignored_load();
    int lat;
    start_load(20'd42);
    tick(4);
    value = 20'd777;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(15);
    load  = 1'b1;
    tick(1);
    n_checks++;
    if ({done, busy, ovf, en, data} !== {1'b1, 1'b0, 1'b0, 6'b000011, 24'h000042}) begin
      n_fail++;
      $display("FAIL ignored_load_result: got done=%b busy=%b res=%h want 1 0 %h",
               done, busy, {ovf, en, data}, {1'b0, 6'b000011, 24'h000042});
    end
    tick(1);
    load = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_at_e22: got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat);
    n_checks++;
    if (lat != 21 || {ovf, en, data} !== ref_model(777, 1'b1)) begin
      n_fail++;
      $display("FAIL e22_result: got lat=%0d res=%h want lat=21 res=%h",
               lat, {ovf, en, data}, ref_model(777, 1'b1));
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int done_seen;
    start_load(20'd654321);
    tick(10);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ovf, en, data} !== {1'b0, 1'b0, 1'b0, 6'b000001, 24'h0}) begin
      n_fail++;
      $display("FAIL abort_reset_values: got busy=%b done=%b ovf=%b en=%b data=%h, want 0 0 0 000001 000000",
               busy, done, ovf, en, data);
    end
    tick(2);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy high, want 0", done_seen);
    end
    start_load(20'd654321);
    wait_done(lat);
    n_checks++;
    if (lat != 21 || {ovf, en, data} !== {1'b0, 6'b111111, 24'h654321}) begin
      n_fail++;
      $display("FAIL abort_reload: got lat=%0d res=%h want lat=21 res=%h",
               lat, {ovf, en, data}, {1'b0, 6'b111111, 24'h654321});
    end
  endtask

  task automatic test_no_blank();
    int lat;
    start_load(20'd7);
    wait_done(lat);
    n_checks++;
    if ({done1, ovf1, en1, data1} !== {1'b1, 1'b0, 6'b111111, 24'h000007}) begin
      n_fail++;
      $display("FAIL no_blank_7: got done=%b res=%h want 1 %h",
               done1, {ovf1, en1, data1}, {1'b0, 6'b111111, 24'h000007});
    end
    n_checks++;
    if (en !== 6'b000001) begin
      n_fail++;
      $display("FAIL blank_7_enables: got %b want 000001", en);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] v;
    logic [30:0] exp_v;
    int cycles;
    v = 20'($urandom_range(0, 1048575));
    value = v;
    exp_q.push_back(ref_model(v, 1'b1));
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      do begin
        tick(1);
        cycles++;
      end while (done !== 1'b1 && cycles < 40);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (cycles != 22 || {ovf, en, data} !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got interval=%0d res=%h want interval=22 res=%h",
                 k, cycles, {ovf, en, data}, exp_v);
      end
      if (k < 3) begin
        v = 20'($urandom_range(0, 999999));
        value = v;
        exp_q.push_back(ref_model(v, 1'b1));
      end else begin
        load = 1'b0;
      end
    end
    tick(2);
  endtask

  task automatic test_random();
    logic [19:0] v;
    logic [30:0] exp_v;
    logic [30:0] exp1_v;
    int lat;
    for (int k = 0; k < 10; k++) begin
      v = (k % 2 == 1) ? 20'($urandom_range(0, 9999)) : 20'($urandom_range(0, 1048575));
      exp_q.push_back(ref_model(v, 1'b1));
      exp1_q.push_back(ref_model(v, 1'b0));
      start_load(v);
      value = 20'($urandom);
      wait_done(lat);
      exp_v  = exp_q.pop_front();
      exp1_v = exp1_q.pop_front();
      n_checks++;
      if (lat != 21 || {ovf, en, data} !== exp_v || {ovf1, en1, data1} !== exp1_v) begin
        n_fail++;
        $display("FAIL random_%0d value=%0d: got lat=%0d res=%h full=%h want lat=21 res=%h full=%h",
                 k, v, lat, {ovf, en, data}, {ovf1, en1, data1}, exp_v, exp1_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sequence();
    test_boundary();
    test_ignored_load();
    test_reset_abort();
    test_no_blank();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/segs_bcd_feeder.md
# segs_bcd_feeder

Sequential binary-to-BCD converter that sits directly upstream of the six-digit seven-segment scan controller. It accepts a 20-bit unsigned binary value on a load strobe and converts it by iterative double-dabble, one bit per cycle. It presents six packed BCD digits plus per-digit display enables, with leading-zero blanking, ready to drive the scan controller's `Data[23:0]` and `DisplayEnables[5:0]` inputs. Outputs hold the last completed result during a conversion, so the display never shows partial values.

## Interface
- `BLANK_LEADING`, default 1: 1 = suppress leading zero digits; 0 = all six digits always enabled.
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Load`  in  1  start strobe; accepted only on a rising edge where `Busy`=0.
- `Value`  in  20  unsigned binary value to display; sampled when `Load` is accepted.
- `Busy`  out  1  high while a conversion is in progress.
- `Done`  out  1  one-cycle pulse when new `Data`/`DisplayEnables` become valid.
- `Overflow`  out  1  last completed conversion had `Value` > 999999.
- `Data`  out  24  six BCD digits; [3:0] is the ones digit, [23:20] is the hundred-thousands digit.
- `DisplayEnables`  out  6  bit i enables digit i.

## Operation
- FSM states:
  - IDLE: `Load`=1 captures `Value` into a 20-bit shift register, clears the 24-bit BCD accumulator, sets the bit counter to 20, flags overflow if `Value` > 20'd999999, and moves to CONV.
  - CONV: each cycle, every accumulator nibble that is ≥5 has 3 added (all six nibbles in parallel, 4-bit add, no carry between nibbles). The accumulator and shift register then shift left together by 1, taking the shift register MSB into accumulator bit 0. The counter decrements. When the counter reaches 0 after the 20th shift, the FSM moves to FINISH.
  - FINISH: registers the outputs, pulses `Done`, and returns to IDLE.
- Result registration in FINISH:
  - Normal: `Data` = accumulator, `Overflow` = 0.
  - Overflow flagged: `Data` = 24'h999999 (saturate), `DisplayEnables` = 6'b111111, `Overflow` = 1.
  - `BLANK_LEADING`=1, no overflow: `DisplayEnables[i]` = 1 if digit i or any higher digit is nonzero. `DisplayEnables[0]` is always 1, so a value of 0 shows a single "0".
  - `BLANK_LEADING`=0: `DisplayEnables` = 6'b111111.
- `Load` in CONV or FINISH is ignored. No queueing; the caller must re-assert `Load` after `Busy` falls.
- `Value` changes after acceptance have no effect on the current conversion.
- `Data`, `DisplayEnables` and `Overflow` change only in FINISH or on reset.

## Timing
- Reset values (asynchronous, whenever `Reset_n`=0): state IDLE, `Busy`=0, `Done`=0, `Overflow`=0, `Data`=24'h000000, `DisplayEnables`=6'b000001, counter 0, shift registers 0.
- Let edge E0 be the edge that accepts `Load`:
  - `Busy` is 1 from after E0 through FINISH; it is 0 again after E21.
  - Shifts occur on E1..E20.
  - FINISH is registered on E21: outputs update after E21, and `Done`=1 for exactly the cycle following E21.
- Latency from accepting edge to valid outputs: 21 clocks. Throughput: one conversion per 22 clocks. The earliest next accept is E22, because `Load` is seen with `Busy`=0 in the cycle after E21.
- `Load` held high continuously restarts a conversion at each opportunity, i.e. every 22 clocks.
- `Reset_n` asserted mid-conversion aborts immediately and returns all outputs to their reset values; no `Done` is produced for the aborted conversion.
- `Busy` and `Done` are registered outputs, with no combinational path from `Load`.

## Test plan
- Reset, then load 0 → after 21 clocks: `Data`=24'h000000, `DisplayEnables`=6'b000001, `Done` high for 1 cycle, `Overflow`=0.
- Load 123456 → `Data`=24'h123456, `DisplayEnables`=6'b111111. Then load 1007 → `Data`=24'h001007, `DisplayEnables`=6'b001111. `Data` holds 24'h123456 throughout the second conversion.
- Load 999999 → `Data`=24'h999999, `Overflow`=0. Load 1000000 → `Data`=24'h999999, `DisplayEnables`=6'b111111, `Overflow`=1. Load 5 → `Overflow` returns to 0, `DisplayEnables`=6'b000001.
- Load 42, then pulse `Load` with `Value`=777 at E5 and at E21 → both ignored. Result is 24'h000042 with enables 6'b000011. A `Load` at E22 is accepted.
- `Reset_n` low at E10 of a conversion of 654321 → outputs return to reset values at once, and no `Done` is produced. The next load of 654321 completes normally.
- `BLANK_LEADING`=0, load 7 → `Data`=24'h000007, `DisplayEnables`=6'b111111.
